// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared 16-bit memory port: grants fetch or load/store with a
// data-priority streak limit, sequences IDLE/ISSUE/WAIT/RESP and returns results.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STR_W = $clog2(STREAK_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [STR_W-1:0]  streak_q, streak_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              mem_sel_q, mem_sel_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              streak_full;

    // Fetch only overrides data priority once data has won STREAK_MAX times in a row.
    always_comb begin
        streak_full = (streak_q == STR_W'(STREAK_MAX));
        if_gnt      = (state_q == IDLE) && if_req && (!d_req || streak_full);
        d_gnt       = (state_q == IDLE) && d_req && !(if_req && streak_full);
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mem_sel_d   = mem_sel_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_gnt) begin
                    state_d    = ISSUE;
                    streak_d   = '0;
                    we_d       = 1'b0;
                    mem_sel_d  = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = if_addr;
                end else if (d_gnt) begin
                    state_d     = ISSUE;
                    we_d        = d_we;
                    mem_sel_d   = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (!if_req)
                        streak_d = '0;
                    else if (!streak_full)
                        streak_d = streak_q + STR_W'(1);
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(MEM_LAT);
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = RESP;
                    if_rvalid_d = !mem_sel_q;
                    d_done_d    = mem_sel_q;
                    if (!we_q) begin
                        if (mem_sel_q)
                            d_rdata_d = mem_rdata;
                        else
                            if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mem_sel_q   <= mem_sel_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_sel   = mem_sel_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single 16-bit memory port shared by instruction fetch and load/store. It accepts one request per transaction, grants it by priority with an anti-starvation streak limit, and drives the memory command. It also drives the select of the 16-bit address/data 2:1 mux in front of memory, and returns read data or write completion to the winner. It sits between the fetch stage, the MEM stage and the unified memory.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range ≥1
- STREAK_MAX, 4, maximum consecutive data grants while fetch waits; legal range ≥1

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address; sampled only in the grant cycle
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched word
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle (combinational)
- d_done  out  1  one-cycle pulse: load data valid or store complete
- d_rdata  out  DATA_W  loaded word
- mem_sel  out  1  mux select: 0 = fetch, 1 = data
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE → ISSUE (1 cycle) → WAIT (MEM_LAT cycles) → RESP (1 cycle) → IDLE.
- Grants are made only in IDLE. In a grant cycle exactly one of if_gnt or d_gnt is high.
- On grant, the winner's addr, wdata and we are captured, and the owner is recorded in mem_sel.
- Requesters hold their inputs valid only in the grant cycle. A request left high after its grant is a new request.
- Arbitration:
  - With only one requester, that requester wins.
  - With both requesting, data wins unless streak == STREAK_MAX, in which case fetch wins.
- streak counter:
  - +1 on a data grant while if_req is high (saturates at STREAK_MAX).
  - Cleared on a fetch grant.
  - Cleared on a data grant while if_req is low.
- A fetch is always a read, so mem_we = 0 for fetches.
- ISSUE: mem_en = 1, and mem_we = captured we.
- mem_addr, mem_wdata and mem_sel are registered. They hold from ISSUE through RESP and keep their last values in IDLE.
- WAIT: a down-counter is loaded with MEM_LAT in ISSUE. mem_rdata is captured on the edge ending the last WAIT cycle, for reads only.
- RESP:
  - Fetch owner: if_rvalid pulses.
  - Data owner: d_done pulses.
  - if_rdata and d_rdata update only on their own reads. A store leaves d_rdata unchanged.
- Requests arriving outside IDLE are ignored until IDLE. There is no queueing.
- Reset (asynchronous, any state):
  - State returns to IDLE and streak clears.
  - mem_en, mem_we, mem_sel, if_rvalid and d_done are 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata are 0.
  - Any in-flight transaction is dropped with no response pulse.

## Timing
- Grant cycle T: gnt high (combinational from IDLE and the req inputs).
- T+1: ISSUE, mem_en high.
- T+2 .. T+1+MEM_LAT: WAIT.
- T+2+MEM_LAT: RESP, rvalid/done high.
- T+3+MEM_LAT: IDLE, next grant possible.
- Throughput is one access per MEM_LAT+3 cycles.
- The memory must present mem_rdata valid exactly MEM_LAT cycles after the mem_en cycle.
- Simultaneous requests are resolved in the same cycle; there is no extra latency for arbitration.

## Test plan
- Reset, then a single fetch:
  - Stimulus: if_req=1, if_addr=0x0010 at T=0; memory returns 0xABCD.
  - Response: if_gnt at 0; mem_en=1, mem_sel=0, mem_addr=0x0010 at 1; if_rvalid=1, if_rdata=0xABCD at 4 (MEM_LAT=2).
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234.
  - Response: mem_en=1, mem_we=1, mem_sel=1, mem_wdata=0x1234 in ISSUE; d_done at T+4; d_rdata unchanged.
- Both requesting continuously, loads only:
  - Grant sequence: D,D,D,D,F,D,D,D,D,F…
  - Response: streak reaches 4, then fetch wins; no two fetch grants are adjacent while d_req is high.
- Requests held high during ISSUE/WAIT:
  - Response: no gnt outside IDLE; mem_en pulses exactly once per transaction.
- rst_n deasserted in WAIT of a load:
  - Response: all outputs 0 immediately (asynchronous); no d_done afterwards; a new request after release completes normally.
- MEM_LAT=1 build:
  - Response: rvalid at T+3; captured rdata is the value mem_rdata presents at T+2.
